// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for a 5-stage MIPS pipeline
//   in : d_rs/d_rt, d_tuse_rs/d_tuse_rt, d_wa/d_we/d_tnew, d_md/d_md_use of the D-stage instruction
//   out: stall (PC, IF/ID), flush_e (ID/EX), fwd_rs_d/fwd_rt_d, fwd_rs_e/fwd_rt_e, md_busy, stall_cnt
//   HAZARD_PERF_EN builds a saturating stall-cycle counter on stall_cnt; without it stall_cnt is 0.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_wa,
  input  logic        d_we,
  input  logic [1:0]  d_tnew,
  input  logic [1:0]  d_md,
  input  logic        d_md_use,
  output logic        stall,
  output logic        flush_e,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);
  localparam int MAXC = MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC;
  localparam int CW = $clog2(MAXC + 1);
  logic [4:0] e_wa_q, e_rs_q, e_rt_q, m_wa_q, w_wa_q, e_wa_d, e_rs_d, e_rt_d;
  logic e_we_q, m_we_q, w_we_q, e_we_d;
  logic [1:0] e_tnew_q, m_tnew_q, e_md_q, e_tnew_d, m_tnew_d, e_md_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic e_live, m_live, w_live, rs_stall, rt_stall, md_stall;
  assign e_live = e_we_q && e_wa_q != 5'd0;
  assign m_live = m_we_q && m_wa_q != 5'd0;
  assign w_live = w_we_q && w_wa_q != 5'd0;
  // the youngest matching stage alone decides whether the operand is late
  assign rs_stall = d_rs != 5'd0 && d_tuse_rs != 2'd3 &&
                    (e_live && e_wa_q == d_rs ? e_tnew_q > d_tuse_rs
                                              : m_live && m_wa_q == d_rs && m_tnew_q > d_tuse_rs);
  assign rt_stall = d_rt != 5'd0 && d_tuse_rt != 2'd3 &&
                    (e_live && e_wa_q == d_rt ? e_tnew_q > d_tuse_rt
                                              : m_live && m_wa_q == d_rt && m_tnew_q > d_tuse_rt);
  // a start sitting in E has not loaded the countdown yet but must still block
  assign md_stall = d_md_use && (md_cnt_q != '0 || e_md_q == 2'b01 || e_md_q == 2'b10);
  assign stall    = rs_stall || rt_stall || md_stall;
  assign flush_e  = stall;
  assign md_busy  = md_cnt_q != '0;
  assign fwd_rs_d = d_rs == 5'd0 ? 2'd0 :
                    e_live && e_wa_q == d_rs && e_tnew_q == 2'd0 ? 2'd1 :
                    m_live && m_wa_q == d_rs && m_tnew_q == 2'd0 ? 2'd2 :
                    w_live && w_wa_q == d_rs ? 2'd3 : 2'd0;
  assign fwd_rt_d = d_rt == 5'd0 ? 2'd0 :
                    e_live && e_wa_q == d_rt && e_tnew_q == 2'd0 ? 2'd1 :
                    m_live && m_wa_q == d_rt && m_tnew_q == 2'd0 ? 2'd2 :
                    w_live && w_wa_q == d_rt ? 2'd3 : 2'd0;
  assign fwd_rs_e = m_live && m_wa_q == e_rs_q && m_tnew_q == 2'd0 ? 2'd2 :
                    w_live && w_wa_q == e_rs_q ? 2'd3 : 2'd0;
  assign fwd_rt_e = m_live && m_wa_q == e_rt_q && m_tnew_q == 2'd0 ? 2'd2 :
                    w_live && w_wa_q == e_rt_q ? 2'd3 : 2'd0;
  always_comb begin
    e_wa_d   = stall ? 5'd0 : d_wa;
    e_we_d   = stall ? 1'b0 : d_we;
    e_tnew_d = stall ? 2'd0 : d_tnew;
    e_rs_d   = stall ? 5'd0 : d_rs;
    e_rt_d   = stall ? 5'd0 : d_rt;
    e_md_d   = stall ? 2'd0 : d_md;
    m_tnew_d = e_tnew_q == 2'd0 ? 2'd0 : e_tnew_q - 2'd1;
    md_cnt_d = e_md_q == 2'b01 ? CW'(MULT_CYC) :
               e_md_q == 2'b10 ? CW'(DIV_CYC) :
               md_cnt_q != '0 ? md_cnt_q - CW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {e_wa_q, e_we_q, e_tnew_q, e_rs_q, e_rt_q, e_md_q} <= '0;
      {m_wa_q, m_we_q, m_tnew_q, w_wa_q, w_we_q} <= '0;
      md_cnt_q <= '0;
    end else begin
      {e_wa_q, e_we_q, e_tnew_q, e_rs_q, e_rt_q, e_md_q} <= {e_wa_d, e_we_d, e_tnew_d, e_rs_d, e_rt_d, e_md_d};
      {m_wa_q, m_we_q, m_tnew_q} <= {e_wa_q, e_we_q, m_tnew_d};
      {w_wa_q, w_we_q} <= {m_wa_q, m_we_q};
      md_cnt_q <= md_cnt_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against an age-based model
module tb_hazard_ctrl;
  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] wa;
    logic       we;
    logic [1:0] tnew, md;
    logic       md_use;
  } ins_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md;
  logic d_we, d_md_use;
  logic stall, flush_e, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [31:0] stall_cnt;
  int total = 0, bad = 0;
  ins_t hist[$];
  int cyc, md_s, md_len;
  int unsigned exp_cnt;
  logic obs_stall;
  logic [1:0] obs_rs_d, obs_rt_d, obs_rs_e;
  logic [31:0] obs_cnt;
  int busy_seen;
  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_we(d_we), .d_tnew(d_tnew), .d_md(d_md), .d_md_use(d_md_use),
    .stall(stall), .flush_e(flush_e), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic ins_t mk(input int rs, rt, tur, tut, wa, we, tnew, md, mu);
    ins_t x;
    x.rs = 5'(rs); x.rt = 5'(rt); x.tuse_rs = 2'(tur); x.tuse_rt = 2'(tut);
    x.wa = 5'(wa); x.we = 1'(we); x.tnew = 2'(tnew); x.md = 2'(md); x.md_use = 1'(mu);
    return x;
  endfunction
  function automatic ins_t rnd();
    ins_t x;
    x.rs = 5'($urandom_range(0, 7)); x.rt = 5'($urandom_range(0, 7));
    x.tuse_rs = 2'($urandom % 4); x.tuse_rt = 2'($urandom % 4);
    x.wa = 5'($urandom_range(0, 7)); x.we = ($urandom % 4) != 0; x.tnew = 2'($urandom % 4);
    x.md = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    x.md_use = x.md != 2'd0 || $urandom % 8 == 0;
    return x;
  endfunction
  // hist[a] is the instruction a cycles past E entry; its result is pending for max(tnew-a,0) more cycles
  function automatic int rem(input ins_t x, input int age);
    return int'(x.tnew) > age ? int'(x.tnew) - age : 0;
  endfunction
  function automatic logic live(input ins_t x);
    return x.we && x.wa != 5'd0;
  endfunction
  function automatic logic m_dstall(input logic [4:0] r, input logic [1:0] tu);
    if (r == 5'd0 || tu == 2'd3) return 1'b0;
    for (int a = 0; a < 2; a++)
      if (live(hist[a]) && hist[a].wa == r) return rem(hist[a], a) > int'(tu);
    return 1'b0;
  endfunction
  function automatic logic [1:0] m_fwd_d(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    for (int a = 0; a < 3; a++)
      if (live(hist[a]) && hist[a].wa == r && (a == 2 || rem(hist[a], a) == 0)) return 2'(a + 1);
    return 2'd0;
  endfunction
  function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
    for (int a = 1; a < 3; a++)
      if (live(hist[a]) && hist[a].wa == r && (a == 2 || rem(hist[a], a) == 0)) return 2'(a + 1);
    return 2'd0;
  endfunction
  function automatic logic m_busy();
    return cyc - md_s >= 1 && cyc - md_s <= md_len;
  endfunction
  function automatic logic m_stall(input ins_t d);
    logic md_st;
    md_st = d.md_use && (hist[0].md == 2'd1 || hist[0].md == 2'd2 || m_busy());
    return m_dstall(d.rs, d.tuse_rs) || m_dstall(d.rt, d.tuse_rt) || md_st;
  endfunction
  function automatic logic [31:0] m_cnt();
`ifdef HAZARD_PERF_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction
  task automatic model_reset();
    hist = {};
    repeat (3) hist.push_back('0);
    cyc = 0; md_s = -100; md_len = 0; exp_cnt = 0;
  endtask
  task automatic drive(input ins_t d);
    d_rs = d.rs; d_rt = d.rt; d_tuse_rs = d.tuse_rs; d_tuse_rt = d.tuse_rt;
    d_wa = d.wa; d_we = d.we; d_tnew = d.tnew; d_md = d.md; d_md_use = d.md_use;
  endtask
  task automatic step(input ins_t d);
    logic es;
    drive(d);
    #1;
    es = m_stall(d);
    chk("stall", stall, es);
    chk("flush_e", flush_e, es);
    chk("fwd_rs_d", fwd_rs_d, m_fwd_d(d.rs));
    chk("fwd_rt_d", fwd_rt_d, m_fwd_d(d.rt));
    chk("fwd_rs_e", fwd_rs_e, m_fwd_e(hist[0].rs));
    chk("fwd_rt_e", fwd_rt_e, m_fwd_e(hist[0].rt));
    chk("md_busy", md_busy, m_busy());
    chk("stall_cnt", stall_cnt, m_cnt());
    obs_stall = stall; obs_rs_d = fwd_rs_d; obs_rt_d = fwd_rt_d; obs_rs_e = fwd_rs_e; obs_cnt = stall_cnt;
    if (md_busy) busy_seen++;
    @(posedge clk);
    if (hist[0].md == 2'd1 || hist[0].md == 2'd2) begin
      md_s = cyc;
      md_len = hist[0].md == 2'd1 ? 5 : 10;
    end
    hist.push_front(es ? ins_t'('0) : d);
    void'(hist.pop_back());
    if (es) exp_cnt++;
    cyc++;
    @(negedge clk);
  endtask
  task automatic issue(input ins_t d, output int n);
    n = 0;
    step(d);
    while (obs_stall && n < 40) begin
      n++;
      step(d);
    end
    if (obs_stall) chk("issue_bound", obs_stall, 1'b0);
  endtask
  task automatic do_reset();
    drive(mk(0, 0, 3, 3, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush", flush_e, 1'b0);
    chk("rst_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}, 8'd0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    ins_t nop, cur;
    int n;
    nop = mk(0, 0, 3, 3, 0, 0, 0, 0, 0);
    drive(nop);
    model_reset();
    @(negedge clk);
    do_reset();
    issue(mk(0, 0, 3, 3, 9, 1, 2, 0, 0), n);
    issue(mk(9, 0, 1, 3, 10, 1, 1, 0, 0), n);
    chk("lw_use_stalls", n, 1);
    step(nop);
    chk("lw_use_fwd_e", obs_rs_e, 2'd3);
    do_reset();
    issue(mk(0, 0, 3, 3, 8, 1, 1, 0, 0), n);
    issue(mk(8, 0, 0, 3, 0, 0, 0, 0, 0), n);
    chk("beq_stalls", n, 1);
    chk("beq_fwd_d", obs_rs_d, 2'd2);
    do_reset();
    issue(mk(0, 0, 3, 3, 0, 1, 1, 0, 0), n);
    issue(mk(0, 0, 0, 0, 11, 1, 1, 0, 0), n);
    chk("r0_stalls", n, 0);
    chk("r0_fwd_d", {obs_rs_d, obs_rt_d}, 4'd0);
    step(nop);
    chk("r0_fwd_e", obs_rs_e, 2'd0);
    do_reset();
    issue(mk(0, 0, 3, 3, 0, 0, 0, 2, 1), n);
    busy_seen = 0;
    issue(mk(0, 0, 3, 3, 12, 1, 1, 0, 1), n);
    chk("div_stalls", n, 11);
    chk("div_busy_cycles", busy_seen, 10);
`ifdef HAZARD_PERF_EN
    chk("div_perf_cnt", obs_cnt, 32'd11);
`else
    chk("div_perf_cnt", obs_cnt, 32'd0);
`endif
    do_reset();
    issue(mk(0, 0, 3, 3, 5, 1, 1, 0, 0), n);
    issue(mk(0, 0, 3, 3, 5, 1, 1, 0, 0), n);
    issue(mk(5, 0, 1, 3, 13, 1, 1, 0, 0), n);
    chk("b2b_stalls", n, 0);
    step(nop);
    chk("b2b_fwd_e", obs_rs_e, 2'd2);
    do_reset();
    issue(mk(0, 0, 3, 3, 0, 0, 0, 2, 1), n);
    issue(mk(0, 0, 3, 3, 9, 1, 2, 0, 0), n);
    drive(mk(9, 0, 1, 3, 10, 1, 1, 0, 0));
    #1;
    chk("mid_pre_stall", stall, 1'b1);
    chk("mid_pre_busy", md_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_flush", flush_e, 1'b0);
    chk("mid_rst_busy", md_busy, 1'b0);
    chk("mid_rst_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}, 8'd0);
    @(negedge clk);
    do_reset();
    cur = rnd();
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) do_reset();
      step(cur);
      if (!obs_stall) cur = rnd();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
